// File: rtl/mac_lane_array_if.sv
`default_nettype none
// ============================================================================
//  Module   : mac_lane_array_if
//  Purpose  : Bundles the tile control, operand stream and result stream of
//             the multi-lane MAC engine. The master side is the sequencer or
//             SRAM readout feeding the engine. The slave side is the engine.
//  Revision : 1.0  initial release
// ============================================================================
interface mac_lane_array_if #(
    parameter int BW      = 4,
    parameter int PSUM_BW = 16,
    parameter int LANES   = 8,
    parameter int CNT_BW  = 8
);
    // Tile control, sampled by the engine only while it is idle
    logic                     start;
    logic [CNT_BW-1:0]        len;
    logic                     act_signed;
    logic                     sat_en;

    // Operand stream: one activation/weight pair per lane per beat
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*BW-1:0]      a;
    logic [LANES*BW-1:0]      b;

    // Result stream: one beat per tile
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*PSUM_BW-1:0] out;
    logic [LANES-1:0]         ovf;
    logic                     busy;

    modport master (
        output start, len, act_signed, sat_en,
        output in_valid, a, b,
        output out_ready,
        input  in_ready, out_valid, out, ovf, busy
    );

    modport slave (
        input  start, len, act_signed, sat_en,
        input  in_valid, a, b,
        input  out_ready,
        output in_ready, out_valid, out, ovf, busy
    );
endinterface
`default_nettype wire

// File: rtl/mac_lane_array.sv
`default_nettype none
// ============================================================================
//  Module   : mac_lane_array
//  Purpose  : LANES independent multiply-accumulate lanes. Each lane sums
//             len products a*b into a PSUM_BW accumulator. Activations can be
//             signed or unsigned. Weights are always signed. The accumulator
//             can saturate or wrap. There is a two-stage pipeline: an operand
//             register, then the accumulate. A tile sequencer runs
//             IDLE -> ACC -> DRAIN -> DONE.
//  Notes    : PSUM_BW must exceed 2*BW so a single product always fits.
//  Revision : 1.0  initial release
// ============================================================================
module mac_lane_array #(
    parameter int BW      = 4,
    parameter int PSUM_BW = 16,
    parameter int LANES   = 8,
    parameter int CNT_BW  = 8
) (
    input  wire logic       clk,
    input  wire logic       reset,      // asynchronous, active low
    mac_lane_array_if.slave bus
);

    typedef enum logic [1:0] {
        c_st_idle  = 2'd0,
        c_st_acc   = 2'd1,
        c_st_drain = 2'd2,
        c_st_done  = 2'd3
    } state_t;

    localparam logic [PSUM_BW-1:0] c_sat_max = {1'b0, {(PSUM_BW-1){1'b1}}};
    localparam logic [PSUM_BW-1:0] c_sat_min = {1'b1, {(PSUM_BW-1){1'b0}}};
    localparam logic [CNT_BW-1:0]  c_cnt_one = CNT_BW'(1);

    // Sequencer state and registered handshake outputs
    state_t                   r_state;
    logic [CNT_BW-1:0]        r_beats_left;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic                     r_busy;

    // Mode bits are latched at start, so later changes on the pins are ignored
    logic                     r_act_signed;
    logic                     r_sat_en;

    // Stage 1: captured operands for the beat accepted on the previous edge
    logic                     r_s1_valid;
    logic [LANES*BW-1:0]      r_s1_a;
    logic [LANES*BW-1:0]      r_s1_b;

    // Stage 2: accumulators and sticky overflow flags
    logic [LANES*PSUM_BW-1:0] r_acc;
    logic [LANES-1:0]         r_ovf;

    logic                     w_accept;
    logic                     w_start;
    logic [LANES*PSUM_BW-1:0] w_acc_next;
    logic [LANES-1:0]         w_lane_ovf;

    // A beat is only taken while ready is high. Ready drops on the edge that
    // takes the final beat, so the beat count can never wrap.
    assign w_accept = bus.in_valid && r_in_ready;
    assign w_start  = bus.start && (r_state == c_st_idle);

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.out       = r_acc;
    assign bus.ovf       = r_ovf;

    // Per-lane datapath: extend, multiply, add, detect overflow, then clamp or wrap
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [BW-1:0]          w_a_raw;
        logic [BW-1:0]          w_b_raw;
        logic [BW:0]            w_a_ext;
        logic signed [2*BW:0]   w_a_wide;
        logic signed [2*BW:0]   w_b_wide;
        logic signed [2*BW:0]   w_prod;
        logic signed [PSUM_BW:0] w_prod_ext;
        logic signed [PSUM_BW:0] w_acc_ext;
        logic signed [PSUM_BW:0] w_sum;
        logic                   w_ovf;

        // Form the PSUM_BW+1 bit sum so out-of-range results are visible in the top two bits
        always_comb begin
            w_a_raw    = r_s1_a[BW*k +: BW];
            w_b_raw    = r_s1_b[BW*k +: BW];
            w_a_ext    = r_act_signed ? {w_a_raw[BW-1], w_a_raw} : {1'b0, w_a_raw};
            w_a_wide   = {{BW{w_a_ext[BW]}}, w_a_ext};
            w_b_wide   = {{(BW+1){w_b_raw[BW-1]}}, w_b_raw};
            w_prod     = w_a_wide * w_b_wide;
            w_prod_ext = {{(PSUM_BW-2*BW){w_prod[2*BW]}}, w_prod};
            w_acc_ext  = {r_acc[PSUM_BW*k+PSUM_BW-1], r_acc[PSUM_BW*k +: PSUM_BW]};
            w_sum      = w_acc_ext + w_prod_ext;
            w_ovf      = w_sum[PSUM_BW] ^ w_sum[PSUM_BW-1];
        end

        assign w_lane_ovf[k] = w_ovf;

        // On overflow, bit PSUM_BW holds the true sign, which selects the bound to clamp to
        assign w_acc_next[PSUM_BW*k +: PSUM_BW] =
            (w_ovf && r_sat_en) ? (w_sum[PSUM_BW] ? c_sat_min : c_sat_max)
                                : w_sum[PSUM_BW-1:0];
    end

    // Stage 1 operand capture on every accepted beat
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_a <= bus.a;
                r_s1_b <= bus.b;
            end
        end
    end

    // Stage 2 accumulate. Start clears the accumulators and flags for the new tile.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
            r_ovf <= '0;
        end else if (w_start) begin
            r_acc <= '0;
            r_ovf <= '0;
        end else if (r_s1_valid) begin
            r_acc <= w_acc_next;
            r_ovf <= r_ovf | w_lane_ovf;
        end
    end

    // Tile sequencer with registered ready/valid/busy outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= c_st_idle;
            r_beats_left <= '0;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_act_signed <= 1'b0;
            r_sat_en     <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.start) begin
                        r_beats_left <= bus.len;
                        r_act_signed <= bus.act_signed;
                        r_sat_en     <= bus.sat_en;
                        r_busy       <= 1'b1;
                        if (bus.len == '0) begin
                            // An empty tile reports its zero result straight away
                            r_state     <= c_st_done;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state    <= c_st_acc;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                c_st_acc: begin
                    if (w_accept) begin
                        r_beats_left <= r_beats_left - c_cnt_one;
                        if (r_beats_left == c_cnt_one) begin
                            r_in_ready <= 1'b0;
                            r_state    <= c_st_drain;
                        end
                    end
                end
                c_st_drain: begin
                    // Stage 1 empty means the last product is already in the accumulators
                    if (!r_s1_valid) begin
                        r_state     <= c_st_done;
                        r_out_valid <= 1'b1;
                    end
                end
                c_st_done: begin
                    // Result stays stable until taken. A start in this cycle is dropped.
                    if (bus.out_ready) begin
                        r_state     <= c_st_idle;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= c_st_idle;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_lane_array.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mac_lane_array
//  Purpose  : Directed bench for mac_lane_array. It uses hand-computed
//             expected tile results. CNT_BW is widened to 9 so that a single
//             tile can push a 16-bit accumulator past its range.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mac_lane_array;

    localparam int BW      = 4;
    localparam int PSUM_BW = 16;
    localparam int LANES   = 8;
    localparam int CNT_BW  = 9;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    logic [LANES*BW-1:0]      a_v;
    logic [LANES*BW-1:0]      b_v;
    logic [LANES*PSUM_BW-1:0] exp_out;

    mac_lane_array_if #(.BW(BW), .PSUM_BW(PSUM_BW), .LANES(LANES), .CNT_BW(CNT_BW)) bus ();

    mac_lane_array #(.BW(BW), .PSUM_BW(PSUM_BW), .LANES(LANES), .CNT_BW(CNT_BW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_tile(input int n, input logic sgn, input logic sat);
        bus.start      = 1'b1;
        bus.len        = CNT_BW'(n);
        bus.act_signed = sgn;
        bus.sat_en     = sat;
        tick();
        bus.start      = 1'b0;
    endtask

    // Takes one beat with in_valid already high; waits (bounded) for ready first
    task automatic send_beat(input string tag);
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) chk({tag, "_ready_timeout"}, 0, 1);
        tick();
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_out_valid"}, bus.out_valid, 1);
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset          = 1'b0;
        bus.start      = 1'b0;
        bus.len        = '0;
        bus.act_signed = 1'b0;
        bus.sat_en     = 1'b0;
        bus.in_valid   = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.out_ready  = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_out", bus.out, 0);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_busy", bus.busy, 0);
        reset = 1'b1;
        tick();

        // Tile 1: unsigned, len=3; lane0 15*-8, lane7 15*7
        a_v = '0; b_v = '0;
        a_v[0 +: 4] = 4'hF; b_v[0 +: 4] = 4'h8;
        a_v[28 +: 4] = 4'hF; b_v[28 +: 4] = 4'h7;
        start_tile(3, 1'b0, 1'b0);
        chk("t1_in_ready", bus.in_ready, 1);
        chk("t1_busy", bus.busy, 1);
        bus.a = a_v; bus.b = b_v; bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) send_beat("t1");
        bus.in_valid = 1'b0;
        chk("t1_ready_after_last", bus.in_ready, 0);
        chk("t1_valid_e0", bus.out_valid, 0);
        tick();
        chk("t1_valid_e1", bus.out_valid, 0);
        tick();
        chk("t1_valid_e2", bus.out_valid, 1);
        exp_out = '0;
        exp_out[0 +: 16]   = 16'hFE98;
        exp_out[112 +: 16] = 16'h013B;
        chk("t1_out", bus.out, exp_out);
        chk("t1_ovf", bus.ovf, 0);
        release_out();
        chk("t1_valid_clear", bus.out_valid, 0);
        chk("t1_idle", bus.busy, 0);

        // Tile 2: 0xF*0xF in signed then unsigned activation mode
        a_v = '0; b_v = '0;
        a_v[0 +: 4] = 4'hF; b_v[0 +: 4] = 4'hF;
        start_tile(1, 1'b1, 1'b0);
        bus.a = a_v; bus.b = b_v; bus.in_valid = 1'b1;
        send_beat("t2s");
        bus.in_valid = 1'b0;
        wait_out("t2s");
        exp_out = '0; exp_out[0 +: 16] = 16'h0001;
        chk("t2_signed_out", bus.out, exp_out);
        release_out();
        start_tile(1, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        send_beat("t2u");
        bus.in_valid = 1'b0;
        wait_out("t2u");
        exp_out = '0; exp_out[0 +: 16] = 16'hFFF1;
        chk("t2_unsigned_out", bus.out, exp_out);
        release_out();

        // Tile 3: 320 beats; lane0 +105 each, lane1 -120 each; saturate then wrap
        a_v = '0; b_v = '0;
        a_v[0 +: 4] = 4'hF; b_v[0 +: 4] = 4'h7;
        a_v[4 +: 4] = 4'hF; b_v[4 +: 4] = 4'h8;
        start_tile(320, 1'b0, 1'b1);
        bus.a = a_v; bus.b = b_v; bus.in_valid = 1'b1;
        for (int i = 0; i < 320; i++) send_beat("t3s");
        bus.in_valid = 1'b0;
        wait_out("t3s");
        exp_out = '0; exp_out[0 +: 16] = 16'h7FFF; exp_out[16 +: 16] = 16'h8000;
        chk("t3_sat_out", bus.out, exp_out);
        chk("t3_sat_ovf", bus.ovf, 8'h03);
        release_out();
        start_tile(320, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 320; i++) send_beat("t3w");
        bus.in_valid = 1'b0;
        wait_out("t3w");
        exp_out = '0; exp_out[0 +: 16] = 16'h8340; exp_out[16 +: 16] = 16'h6A00;
        chk("t3_wrap_out", bus.out, exp_out);
        chk("t3_wrap_ovf", bus.ovf, 8'h03);
        release_out();

        // Tile 4: len=0 clears the previous result and reports one cycle after start
        start_tile(0, 1'b0, 1'b0);
        chk("t4_out_valid", bus.out_valid, 1);
        chk("t4_in_ready", bus.in_ready, 0);
        chk("t4_out", bus.out, 0);
        chk("t4_ovf", bus.ovf, 0);
        release_out();

        // Tile 5: signed, len=4, bubbles with garbage, mode pins flipped mid-tile
        a_v = '0; b_v = '0;
        a_v[0 +: 4] = 4'hD; b_v[0 +: 4] = 4'h5;
        a_v[12 +: 4] = 4'h7; b_v[12 +: 4] = 4'hF;
        start_tile(4, 1'b1, 1'b0);
        bus.act_signed = 1'b0;
        bus.sat_en     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.a = a_v; bus.b = b_v; bus.in_valid = 1'b1;
            send_beat("t5");
            bus.a = '1; bus.b = {LANES{4'h7}}; bus.in_valid = 1'b0;
            tick();
        end
        chk("t5_no_extra_ready", bus.in_ready, 0);
        bus.in_valid = 1'b1;
        wait_out("t5");
        exp_out = '0; exp_out[0 +: 16] = 16'hFFC4; exp_out[48 +: 16] = 16'hFFE4;
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_valid", bus.out_valid, 1);
            chk("t5_hold_out", bus.out, exp_out);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        bus.len       = CNT_BW'(2);
        tick();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        chk("t5_taken_valid", bus.out_valid, 0);
        chk("t5_taken_busy", bus.busy, 0);
        tick();
        chk("t5_start_ignored", bus.busy, 0);

        // Tile 6: reset after 2 of 4 beats, then a fresh tile
        a_v = '0; b_v = '0;
        a_v[0 +: 4] = 4'h1; b_v[0 +: 4] = 4'h1;
        start_tile(4, 1'b0, 1'b0);
        bus.a = a_v; bus.b = b_v; bus.in_valid = 1'b1;
        send_beat("t6");
        send_beat("t6");
        bus.in_valid = 1'b0;
        exp_out = '0; exp_out[0 +: 16] = 16'h0001;
        chk("t6_partial", bus.out, exp_out);
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_out", bus.out, 0);
        chk("t6_rst_in_ready", bus.in_ready, 0);
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_out_valid", bus.out_valid, 0);
        #2 reset = 1'b1;
        tick();
        a_v = '0; b_v = '0;
        a_v[0 +: 4] = 4'h2; b_v[0 +: 4] = 4'h3;
        start_tile(1, 1'b0, 1'b0);
        bus.a = a_v; bus.b = b_v; bus.in_valid = 1'b1;
        send_beat("t6n");
        bus.in_valid = 1'b0;
        wait_out("t6n");
        exp_out = '0; exp_out[0 +: 16] = 16'h0006;
        chk("t6_new_out", bus.out, exp_out);
        release_out();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
